bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of BCD digits (1..4).
REQ-002 The block SHALL have parameter MOD_MAX, default 99, giving the decimal terminal value (1..10^DIGITS-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have port load_val, input, 4*DIGITS bits: BCD value to load; digit k in bits [4k+3:4k], digit 0 least significant.
REQ-009 The block SHALL have port count, output, 4*DIGITS bits: registered BCD count, same digit packing as load_val.
REQ-010 The block SHALL have port tc, output, 1 bit: combinational terminal-count flag for cascading.
REQ-011 The block SHALL have port wrap, output, 1 bit: registered one-cycle pulse on wrap-around.
REQ-012 The block SHALL have port err, output, 1 bit: registered one-cycle pulse on a rejected load.

Function
REQ-013 Per rising edge, priority SHALL be: reset, then load, then en, then hold.
REQ-014 With en=1, up=1 and count<MOD_MAX, count SHALL become count+1 in decimal, ripple-carrying 9->0 into the next digit.
REQ-015 With en=1, up=1 and count==MOD_MAX, count SHALL become 0 and wrap SHALL be 1 in the following cycle.
REQ-016 With en=1, up=0 and count>0, count SHALL become count-1 in decimal, borrowing 0->9 from the next digit.
REQ-017 With en=1, up=0 and count==0, count SHALL become MOD_MAX and wrap SHALL be 1 in the following cycle.
REQ-018 tc SHALL equal en & ((up & count==MOD_MAX) | (~up & count==0)), with zero-cycle latency.
REQ-019 A load SHALL be accepted when every nibble of load_val is <=9 and its decimal value is <=MOD_MAX; count SHALL take load_val on that edge.
REQ-020 A load with any nibble >9 or value >MOD_MAX SHALL set count to 0 and pulse err for one cycle.
REQ-021 A load SHALL never pulse wrap, even when en=1 in the same cycle.
REQ-022 wrap and err SHALL be 0 in every cycle not named in REQ-015, REQ-017 and REQ-020.
REQ-023 A direction change SHALL take effect on the first edge where the new value of up is sampled, with no lost or extra count.
REQ-024 Every nibble of count SHALL be a valid BCD digit (0..9) in every cycle after reset.
REQ-025 count SHALL never exceed MOD_MAX.
REQ-026 With en=0 and load=0, count SHALL hold, and wrap and err SHALL be 0.

Reset
REQ-027 While reset=1 at a rising edge, count, wrap and err SHALL be 0 after that edge, regardless of load or en.
REQ-028 A reset asserted mid-count SHALL take effect on the next edge, with no partial update.
REQ-029 The first count SHALL occur on the first edge with reset=0 and en=1.
REQ-030 Outputs before the first reset edge SHALL be unspecified.

Verification
REQ-031 DIGITS=2, MOD_MAX=99, up=1, en=1, 100 edges from reset: count runs 01..99,00; wrap pulses only after 99->00; tc=1 only while count=99.
REQ-032 DIGITS=1, MOD_MAX=9, up=0, en=1 from reset: count=9 after the first edge with wrap=1, then 8..0; tc=1 while count=0.
REQ-033 DIGITS=2, MOD_MAX=59, load_val=0x59, then up count: count=0x00 with wrap=1. Then load_val=0x6A: count=0x00, err=1 for one cycle. Then load_val=0x60: err=1.
REQ-034 Count up to 0x19, drop en for 3 cycles, toggle up=0: count holds at 0x19, then steps 0x18, 0x17.
REQ-035 DIGITS=3, MOD_MAX=999, count at 0x499 with load=1, load_val=0x123, en=1 on the same edge: count=0x123, wrap=0. Then reset=1 with en=1: count=0x000.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with programmable terminal value,
// validated parallel load, cascade flag and wrap/error pulses.
module bcd_updown_counter #(
  parameter int DIGITS  = 2,
  parameter int MOD_MAX = 99
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MOD_MAX);

  logic [W-1:0] r_count;
  logic         r_wrap;
  logic         r_err;

  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic         w_c;
  logic         w_b;
  logic         w_valid;
  logic         w_at_max;
  logic         w_at_zero;

  // Ripple carry/borrow across digits, least significant first.
  always_comb begin
    w_inc = r_count;
    w_dec = r_count;
    w_c   = 1'b1;
    w_b   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_c) begin
        if (r_count[4*k +: 4] == 4'd9) begin
          w_inc[4*k +: 4] = 4'd0;
        end else begin
          w_inc[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
          w_c = 1'b0;
        end
      end
      if (w_b) begin
        if (r_count[4*k +: 4] == 4'd0) begin
          w_dec[4*k +: 4] = 4'd9;
        end else begin
          w_dec[4*k +: 4] = r_count[4*k +: 4] - 4'd1;
          w_b = 1'b0;
        end
      end
    end
  end

  // Valid BCD compares digit-wise in the same order as plain binary.
  always_comb begin
    w_valid = (load_val <= MAX_BCD);
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) w_valid = 1'b0;
    end
  end

  assign w_at_max  = (r_count == MAX_BCD);
  assign w_at_zero = (r_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (load) begin
        if (w_valid) begin
          r_count <= load_val;
        end else begin
          r_count <= '0;
          r_err   <= 1'b1;
        end
      end else if (en) begin
        if (up) begin
          if (w_at_max) begin
            r_count <= '0;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= w_inc;
          end
        end else begin
          if (w_at_zero) begin
            r_count <= MAX_BCD;
            r_wrap  <= 1'b1;
          end else begin
            r_count <= w_dec;
          end
        end
      end
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign err   = r_err;
  assign tc    = en & ((up & w_at_max) | (~up & w_at_zero));

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter across four parameter sets
// sharing clock and control lines, each with its own load value.
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  logic reset, en, up, load;

  logic [7:0]  lv2, lv59, c2, c59;
  logic [3:0]  lv1, c1;
  logic [11:0] lv3, c3;
  logic tc2, wr2, er2;
  logic tc1, wr1, er1;
  logic tc59, wr59, er59;
  logic tc3, wr3, er3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .MOD_MAX(99)) u_d2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv2), .count(c2), .tc(tc2), .wrap(wr2), .err(er2));

  bcd_updown_counter #(.DIGITS(1), .MOD_MAX(9)) u_d1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv1), .count(c1), .tc(tc1), .wrap(wr1), .err(er1));

  bcd_updown_counter #(.DIGITS(2), .MOD_MAX(59)) u_m59 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv59), .count(c59), .tc(tc59), .wrap(wr59), .err(er59));

  bcd_updown_counter #(.DIGITS(3), .MOD_MAX(999)) u_d3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv3), .count(c3), .tc(tc3), .wrap(wr3), .err(er3));

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0;
    lv1 = '0; lv2 = '0; lv59 = '0; lv3 = '0;

    // Reset with load and en active still clears
    reset = 1'b1; load = 1'b1; en = 1'b1; lv2 = 8'h42;
    tick();
    check("rst_cnt", 32'(c2), 32'h0);
    check("rst_wrap", 32'(wr2), 32'h0);
    check("rst_err", 32'(er2), 32'h0);
    check("rst_cnt3", 32'(c3), 32'h0);

    // Full up sweep, DIGITS=2 MOD_MAX=99
    reset = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    check("up_tc0", 32'(tc2), 32'h0);
    for (int i = 1; i <= 100; i++) begin
      tick();
      check("up_cnt", 32'(c2), bcd(i % 100));
      check("up_wrap", 32'(wr2), 32'(i == 100));
      check("up_tc", 32'(tc2), 32'(i == 99));
    end

    // Down count, DIGITS=1 MOD_MAX=9
    en = 1'b1; up = 1'b0;
    do_reset();
    check("dn_rst", 32'(c1), 32'h0);
    check("dn_tc0", 32'(tc1), 32'h1);
    tick();
    check("dn_wrapv", 32'(c1), 32'h9);
    check("dn_wrap", 32'(wr1), 32'h1);
    for (int v = 8; v >= 0; v--) begin
      tick();
      check("dn_cnt", 32'(c1), 32'(v));
      check("dn_wr0", 32'(wr1), 32'h0);
      check("dn_tc", 32'(tc1), 32'(v == 0));
    end

    // Load handling, MOD_MAX=59
    en = 1'b0; up = 1'b1;
    do_reset();
    load = 1'b1; lv59 = 8'h59;
    tick();
    check("ld59", 32'(c59), 32'h59);
    check("ld59_err", 32'(er59), 32'h0);
    load = 1'b0; en = 1'b1;
    #1;
    check("m59_tc", 32'(tc59), 32'h1);
    tick();
    check("m59_wrv", 32'(c59), 32'h00);
    check("m59_wrap", 32'(wr59), 32'h1);
    en = 1'b0; load = 1'b1; lv59 = 8'h42;
    tick();
    check("ld42", 32'(c59), 32'h42);
    lv59 = 8'h6A;
    tick();
    check("ld6A", 32'(c59), 32'h00);
    check("ld6A_err", 32'(er59), 32'h1);
    load = 1'b0;
    tick();
    check("err_1cyc", 32'(er59), 32'h0);
    check("hold0", 32'(c59), 32'h00);
    load = 1'b1; lv59 = 8'h60;
    tick();
    check("ld60_err", 32'(er59), 32'h1);
    check("ld60", 32'(c59), 32'h00);
    load = 1'b0;

    // Hold and direction change on DIGITS=2
    en = 1'b1; up = 1'b1;
    do_reset();
    for (int i = 0; i < 19; i++) tick();
    check("to19", 32'(c2), 32'h19);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold19", 32'(c2), 32'h19);
      check("hold_wr", 32'(wr2), 32'h0);
    end
    up = 1'b0;
    tick();
    check("hold_up0", 32'(c2), 32'h19);
    en = 1'b1;
    tick();
    check("dn18", 32'(c2), 32'h18);
    tick();
    check("dn17", 32'(c2), 32'h17);
    up = 1'b1;
    tick();
    check("up18", 32'(c2), 32'h18);

    // DIGITS=3: borrow ripple, load priority over count, reset
    en = 1'b0;
    do_reset();
    load = 1'b1; lv3 = 12'h100;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    check("d3_borrow", 32'(c3), 32'h099);
    up = 1'b1;
    tick();
    check("d3_carry", 32'(c3), 32'h100);
    en = 1'b0; load = 1'b1; lv3 = 12'h999;
    tick();
    check("d3_ld999", 32'(c3), 32'h999);
    en = 1'b1; lv3 = 12'h123;
    tick();
    check("d3_ldpri", 32'(c3), 32'h123);
    check("d3_ldnowr", 32'(wr3), 32'h0);
    load = 1'b0;
    tick();
    check("d3_124", 32'(c3), 32'h124);
    reset = 1'b1;
    tick();
    check("d3_rst", 32'(c3), 32'h000);
    check("d3_rstwr", 32'(wr3), 32'h0);
    reset = 1'b0;
    tick();
    check("d3_first", 32'(c3), 32'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
